// File: rtl/nanorv32_rf_wrback_pkg.sv
// nanorv32_rf_wrback_pkg: shared widths, x0 index, FIFO depth and index helper
package nanorv32_rf_wrback_pkg;
  localparam int NANORV32_DATA_MSB = 31;
  localparam int NANORV32_RF_PORTRD_MSB = 4;
  localparam int NANORV32_LSU_BUF_DEPTH = 2;
  typedef logic [NANORV32_RF_PORTRD_MSB:0] rf_idx_t;
  localparam rf_idx_t NANORV32_X0 = '0;
  function automatic logic idx_valid(rf_idx_t i, int n);
    return (i != NANORV32_X0) && (int'(i) < n);
  endfunction
endpackage

// File: rtl/nanorv32_rf_wrback_fifo.sv
// nanorv32_rf_wrback_fifo: synchronous FIFO holding {sel_rd, data} load results
module nanorv32_rf_wrback_fifo import nanorv32_rf_wrback_pkg::*; #(
  parameter int DEPTH = NANORV32_LSU_BUF_DEPTH,
  parameter int W = NANORV32_RF_PORTRD_MSB + NANORV32_DATA_MSB + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign w_push = i_push & ~o_full;
  assign w_pop = i_pop & ~o_empty;
  assign o_data = r_mem[r_rp];
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  // storage write; contents are don't-care while empty so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end
  // pointers and occupancy; simultaneous push/pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/nanorv32_rf_wrback.sv
// nanorv32_rf_wrback: ALU/LSU writeback arbitration plus pending-load scoreboard
module nanorv32_rf_wrback import nanorv32_rf_wrback_pkg::*; #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W = NANORV32_DATA_MSB + 1,
  parameter int LSU_BUF_DEPTH = NANORV32_LSU_BUF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  rf_idx_t           alu_sel_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  rf_idx_t           lsu_sel_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              ld_issue,
  input  rf_idx_t           ld_issue_rd,
  output logic              ld_issue_ok,
  input  rf_idx_t           chk_sel_a,
  input  rf_idx_t           chk_sel_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output rf_idx_t           sel_rd,
  output logic [DATA_W-1:0] rd,
  output logic              write_rd,
  output logic              idle
);
  localparam int IW = NANORV32_RF_PORTRD_MSB + 1;
  localparam int EW = IW + DATA_W;
  localparam int CW = $clog2(LSU_BUF_DEPTH) + 1;
  function automatic logic [NUM_REGS-1:0] f_onehot(rf_idx_t i);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << i;
  endfunction
  function automatic logic f_pend(logic [NUM_REGS-1:0] p, rf_idx_t i);
    return |(p & f_onehot(i));
  endfunction
  logic [NUM_REGS-1:0] r_pending, w_set, w_clr;
  rf_idx_t r_sel_rd, w_sel_idx;
  logic [DATA_W-1:0] r_rd, w_sel_data;
  logic r_write_rd, r_wb_is_lsu;
  logic w_hs, w_push, w_pop, w_sel_lsu, w_sel_v, w_full, w_empty;
  logic [EW-1:0] w_head;
  logic [CW-1:0] w_cnt;
  nanorv32_rf_wrback_fifo #(.DEPTH(LSU_BUF_DEPTH), .W(EW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(w_push),
    .i_data({lsu_sel_rd, lsu_data}),
    .i_pop(w_pop),
    .o_data(w_head),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(w_cnt)
  );
  assign lsu_ready = ~rst & ~w_full;
  assign ld_issue_ok = ~f_pend(r_pending, ld_issue_rd);
  assign hazard_a = f_pend(r_pending, chk_sel_a);
  assign hazard_b = f_pend(r_pending, chk_sel_b);
  assign sel_rd = r_sel_rd;
  assign rd = r_rd;
  assign write_rd = r_write_rd;
  assign idle = (w_cnt == '0) & ~|r_pending & ~r_write_rd;
  // fixed priority ALU > FIFO head > LSU bypass; loads queue once the FIFO is occupied
  always_comb begin
    w_hs = lsu_valid & lsu_ready;
    w_pop = ~alu_valid & ~w_empty;
    w_push = w_hs & (alu_valid | ~w_empty);
    w_sel_lsu = ~alu_valid & (~w_empty | w_hs);
    w_sel_v = alu_valid | w_sel_lsu;
    w_sel_idx = alu_valid ? alu_sel_rd : ~w_empty ? w_head[EW-1:DATA_W] : lsu_sel_rd;
    w_sel_data = alu_valid ? alu_data : ~w_empty ? w_head[DATA_W-1:0] : lsu_data;
    w_set = (ld_issue & ld_issue_ok & idx_valid(ld_issue_rd, NUM_REGS)) ? f_onehot(ld_issue_rd) : '0;
    w_clr = (r_write_rd & r_wb_is_lsu) ? f_onehot(r_sel_rd) : '0;
  end
  // writeback register; x0 and out-of-range indices are consumed without a write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_rd <= '0;
      r_rd <= '0;
      r_write_rd <= 1'b0;
      r_wb_is_lsu <= 1'b0;
    end else begin
      r_write_rd <= w_sel_v & idx_valid(w_sel_idx, NUM_REGS);
      r_wb_is_lsu <= w_sel_lsu;
      if (w_sel_v) begin
        r_sel_rd <= w_sel_idx;
        r_rd <= w_sel_data;
      end
    end
  end
  // scoreboard clears on the LSU write edge; a same-edge issue re-sets the bit
  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else r_pending <= ((r_pending & ~w_clr) | w_set) & {{(NUM_REGS-1){1'b1}}, 1'b0};
  end
`ifndef SYNTHESIS
  a_alu_to_pending: assert property (@(posedge clk) disable iff (rst)
    !(alu_valid && f_pend(r_pending, alu_sel_rd)))
    else $error("ALU result targets a register with a load outstanding");
`endif
endmodule

// File: tb/tb_nanorv32_rf_wrback.sv
// tb_nanorv32_rf_wrback: randomized and directed checks against a queue-based model
module tb_nanorv32_rf_wrback;
  logic clk = 1'b0, rst = 1'b1;
  logic alu_valid = 0, lsu_valid = 0, lsu_ready, ld_issue = 0, ld_issue_ok;
  logic [4:0] alu_sel_rd = 0, lsu_sel_rd = 0, ld_issue_rd = 0, chk_sel_a = 0, chk_sel_b = 0, sel_rd;
  logic [31:0] alu_data = 0, lsu_data = 0, rd;
  logic hazard_a, hazard_b, write_rd, idle;
  int n_chk = 0, n_fail = 0;
  logic a_v, l_v, iss, hs;
  logic [4:0] a_idx, l_idx, iss_rd, ca, cb;
  logic [31:0] a_d, l_d;
  logic [36:0] q[$];
  logic [4:0] outq[$];
  logic [31:0] pend;
  logic m_wr, m_lsu;
  logic [4:0] m_sel;
  logic [31:0] m_rd;
  nanorv32_rf_wrback dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_sel_rd(alu_sel_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_sel_rd(lsu_sel_rd), .lsu_data(lsu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ok(ld_issue_ok),
    .chk_sel_a(chk_sel_a), .chk_sel_b(chk_sel_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .sel_rd(sel_rd), .rd(rd), .write_rd(write_rd), .idle(idle)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic quiet();
    a_v = 0; l_v = 0; iss = 0;
  endtask
  task automatic model_reset();
    q.delete(); outq.delete(); pend = 0; m_wr = 0; m_lsu = 0; m_sel = 0; m_rd = 0;
  endtask
  task automatic cycle();
    logic rdy, ok, sv, sl;
    logic [4:0] si;
    logic [31:0] sd;
    logic [36:0] e;
    alu_valid = a_v; alu_sel_rd = a_idx; alu_data = a_d;
    lsu_valid = l_v; lsu_sel_rd = l_idx; lsu_data = l_d;
    ld_issue = iss; ld_issue_rd = iss_rd; chk_sel_a = ca; chk_sel_b = cb;
    #1;
    rdy = q.size() < 2;
    chk("lsu_ready", lsu_ready, rdy);
    chk("hazard_a", hazard_a, pend[ca]);
    chk("hazard_b", hazard_b, pend[cb]);
    ok = !pend[iss_rd];
    chk("ld_issue_ok", ld_issue_ok, ok);
    hs = l_v && rdy;
    sv = 0; sl = 0; si = 0; sd = 0;
    if (a_v) begin
      sv = 1; si = a_idx; sd = a_d;
      if (hs) q.push_back({l_idx, l_d});
    end else if (q.size() != 0) begin
      e = q.pop_front();
      sv = 1; sl = 1; si = e[36:32]; sd = e[31:0];
      if (hs) q.push_back({l_idx, l_d});
    end else if (hs) begin
      sv = 1; sl = 1; si = l_idx; sd = l_d;
    end
    if (m_wr && m_lsu) pend[m_sel] = 0;
    if (iss && ok) begin
      if (iss_rd != 0) pend[iss_rd] = 1;
      outq.push_back(iss_rd);
    end
    m_wr = sv && si != 0;
    m_lsu = sl;
    if (sv) begin m_sel = si; m_rd = sd; end
    @(posedge clk); #1;
    chk("write_rd", write_rd, m_wr);
    if (m_wr) begin
      chk("sel_rd", sel_rd, m_sel);
      chk("rd", rd, m_rd);
    end
    chk("idle", idle, q.size() == 0 && pend == 0 && !m_wr);
  endtask
  initial begin
    int k, pick, cnt;
    quiet(); a_idx = 0; a_d = 0; l_idx = 0; l_d = 0; iss_rd = 0; ca = 0; cb = 0;
    model_reset();
    // reset held two cycles with an ALU result offered
    rst = 1; alu_valid = 1; alu_sel_rd = 5'd6; alu_data = 32'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_write_rd", write_rd, 0);
    chk("rst_sel_rd", sel_rd, 0);
    chk("rst_rd", rd, 0);
    chk("rst_hazard_a", hazard_a, 0);
    chk("rst_hazard_b", hazard_b, 0);
    chk("rst_idle", idle, 1);
    rst = 0;
    // ALU latency
    a_v = 1; a_idx = 5; a_d = 32'h12345678; cycle();
    a_v = 0; cycle();
    // collision and ordering
    a_v = 1; a_idx = 3; a_d = 32'hA; l_v = 1; l_idx = 7; l_d = 32'hB; cycle();
    a_v = 0; l_idx = 8; l_d = 32'hC; cycle();
    l_v = 0; cycle(); cycle();
    // backpressure: continuous ALU with three loads offered
    k = 0;
    for (int c = 0; c < 12; c++) begin
      a_v = c < 6; a_idx = 5'(10 + c); a_d = $urandom;
      l_v = k < 3; l_idx = 5'(20 + k); l_d = 32'h100 + k;
      cycle();
      if (hs) k++;
    end
    chk("bp_all_accepted", k, 3);
    quiet(); cycle();
    // scoreboard on x9
    iss = 1; iss_rd = 9; ca = 9; cb = 9; cycle();
    iss = 0; cycle();
    l_v = 1; l_idx = outq.pop_front(); l_d = 32'h9999; cycle();
    l_v = 0; cycle(); cycle(); cycle();
    // x0 load result consumed without a write
    l_v = 1; l_idx = 0; l_d = 32'h5A5A; cycle();
    l_v = 0; cycle(); cycle();
    // clear of x4 coinciding with a new issue to x4
    l_v = 1; l_idx = 4; l_d = 32'h44; cycle();
    l_v = 0; iss = 1; iss_rd = 4; cycle();
    iss = 0; ca = 4; cycle();
    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (!l_v && outq.size() != 0 && $urandom_range(0, 2) != 0) begin
        l_v = 1; l_idx = outq.pop_front(); l_d = $urandom;
      end
      a_v = 0;
      if ($urandom_range(0, 9) < 4) begin
        pick = $urandom_range(0, 31);
        if (!pend[pick]) begin a_v = 1; a_idx = 5'(pick); a_d = $urandom; end
      end
      iss = $urandom_range(0, 3) == 0; iss_rd = 5'($urandom_range(0, 31));
      ca = 5'($urandom_range(0, 31)); cb = 5'($urandom_range(0, 31));
      cycle();
      if (hs) l_v = 0;
    end
    // drain outstanding loads
    a_v = 0; iss = 0; cnt = 0;
    while ((outq.size() != 0 || l_v || q.size() != 0 || m_wr || pend != 0) && cnt < 300) begin
      if (!l_v && outq.size() != 0) begin l_v = 1; l_idx = outq.pop_front(); l_d = $urandom; end
      cycle();
      if (hs) l_v = 0;
      cnt++;
    end
    chk("drain_done", cnt < 300, 1);
    // reset in the middle of traffic drops in-flight results
    a_v = 1; a_idx = 12; a_d = 32'h77; l_v = 1; l_idx = 13; l_d = 32'h88; cycle();
    l_v = 1; l_idx = 14; cycle();
    rst = 1; alu_valid = 1; lsu_valid = 1;
    @(posedge clk); #1;
    chk("mid_rst_write_rd", write_rd, 0);
    chk("mid_rst_idle", idle, 1);
    rst = 0; quiet(); model_reset();
    cycle(); cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
